anu_ifetch: RTL and testbench

//  Instruction fetch stage directly upstream of the single-cycle core. Takes the core's PC and

---
 rtl/anu_ifetch_if.sv | 28 ++
 rtl/anu_ifetch.sv | 168 ++++++++++++++++
 tb/tb_anu_ifetch.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/anu_ifetch_if.sv
// Instruction-memory bus between the fetch stage and instruction memory.
// master: fetch side (drives request, receives response); slave: memory side.
interface anu_ifetch_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        input  imem_rsp_err
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        output imem_rsp_err
    );
endinterface

// File: rtl/anu_ifetch.sv
// Instruction fetch stage with a one-entry tagged buffer feeding a single-cycle core.
// Ports: clk, rst_n (sync, active low), pc_i, invalidate_i -> instr_o, stall_o,
//        imem bus (anu_ifetch_if.master), fault_o / fault_cause_o / fault_addr_o.
module anu_ifetch #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int unsigned TIMEOUT   = 64,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         pc_i,
    input  logic                invalidate_i,
    output logic [31:0]         instr_o,
    output logic                stall_o,
    anu_ifetch_if.master        imem,
    output logic                fault_o,
    output logic [1:0]          fault_cause_o,
    output logic [31:0]         fault_addr_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_FAULT
    } state_e;

    localparam bit             TO_EN    = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST =
        TO_EN ? CNT_W'(TIMEOUT - 1) : '0;

    state_e           state_q, state_d;
    logic             buf_valid_q, buf_valid_d;
    logic [31:0]      buf_tag_q, buf_tag_d;
    logic [31:0]      buf_data_q, buf_data_d;
    logic             drop_q, drop_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      req_addr_q, req_addr_d;
    logic [1:0]       cause_q, cause_d;
    logic [31:0]      faddr_q, faddr_d;

    logic hit;
    logic misaligned;
    logic timeout_hit;

    assign hit         = buf_valid_q && (pc_i == buf_tag_q)
                         && (state_q == S_IDLE);
    assign misaligned  = (pc_i[1:0] != 2'b00);
    assign timeout_hit = TO_EN && (cnt_q == CNT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (misaligned) begin
                    state_d = S_FAULT;
                end else if (!hit) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (imem.imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem.imem_rsp_valid) begin
                    state_d = imem.imem_rsp_err ? S_FAULT : S_IDLE;
                end else if (timeout_hit) begin
                    state_d = S_FAULT;
                end
            end
            S_FAULT: state_d = S_FAULT;
        endcase
    end

    // Outputs
    always_comb begin
        stall_o             = ~hit;
        instr_o             = hit ? buf_data_q : NOP_INSTR;
        imem.imem_req_valid = (state_q == S_REQ);
        imem.imem_req_addr  = req_addr_q;
        fault_o             = (state_q == S_FAULT);
        fault_cause_o       = cause_q;
        fault_addr_o        = faddr_q;
    end

    // Buffer, request address, counter and fault record
    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_tag_d   = buf_tag_q;
        buf_data_d  = buf_data_q;
        drop_d      = drop_q;
        cnt_d       = cnt_q;
        req_addr_d  = req_addr_q;
        cause_d     = cause_q;
        faddr_d     = faddr_q;
        unique case (state_q)
            S_IDLE: begin
                if (misaligned) begin
                    cause_d = 2'b01;
                    faddr_d = pc_i;
                end else if (!hit) begin
                    req_addr_d = pc_i;
                end
            end
            S_REQ: cnt_d = '0;
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (imem.imem_rsp_valid) begin
                    if (imem.imem_rsp_err) begin
                        cause_d = 2'b10;
                        faddr_d = req_addr_q;
                    end else if (drop_q || invalidate_i) begin
                        // Stale data: discard, IDLE will refetch.
                        drop_d = 1'b0;
                    end else begin
                        buf_data_d  = imem.imem_rsp_data;
                        buf_tag_d   = req_addr_q;
                        buf_valid_d = 1'b1;
                    end
                end else if (timeout_hit) begin
                    cause_d = 2'b11;
                    faddr_d = req_addr_q;
                end else if (invalidate_i) begin
                    drop_d = 1'b1;
                end
            end
            S_FAULT: ;
        endcase
        if (invalidate_i) begin
            buf_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_valid_q <= 1'b0;
            buf_tag_q   <= '0;
            buf_data_q  <= '0;
            drop_q      <= 1'b0;
            cnt_q       <= '0;
            req_addr_q  <= '0;
            cause_q     <= 2'b00;
            faddr_q     <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_tag_q   <= buf_tag_d;
            buf_data_q  <= buf_data_d;
            drop_q      <= drop_d;
            cnt_q       <= cnt_d;
            req_addr_q  <= req_addr_d;
            cause_q     <= cause_d;
            faddr_q     <= faddr_d;
        end
    end

endmodule

// File: tb/tb_anu_ifetch.sv
// Directed bench for anu_ifetch: vector table plus fault / invalidate sequences.
// A small behavioural memory answers requests after a programmable delay.
module tb_anu_ifetch;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] I0  = 32'h0050_0093;
    localparam logic [31:0] I1  = 32'h00a0_0113;
    localparam logic [31:0] X1  = 32'h0010_0193;
    localparam logic [31:0] X2  = 32'h0020_0193;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic        inv;
    logic [31:0] instr;
    logic        stall;
    logic        fault;
    logic [1:0]  cause;
    logic [31:0] faddr;

    always #5 clk = ~clk;

    anu_ifetch_if bus ();

    anu_ifetch #(
        .NOP_INSTR (NOP),
        .TIMEOUT   (8),
        .CNT_W     (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_i          (pc),
        .invalidate_i  (inv),
        .instr_o       (instr),
        .stall_o       (stall),
        .imem          (bus.master),
        .fault_o       (fault),
        .fault_cause_o (cause),
        .fault_addr_o  (faddr)
    );

    typedef struct {
        logic [31:0] pc;
        bit          inv;
        bit          rdy;
        bit          e_stall;
        logic [31:0] e_instr;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_fault;
        logic [1:0]  e_cause;
        logic [31:0] e_faddr;
    } vec_t;

    vec_t        tbl[$];
    int          n_chk  = 0;
    int          n_fail = 0;

    logic [31:0] mem [0:7];
    int          delay;
    bit          mem_en;
    bit          err_mode;
    int          cnt;
    logic [31:0] pend_addr;

    function automatic vec_t mk(logic [31:0] p, bit i, bit r, bit st,
                                logic [31:0] ins, bit rq, logic [31:0] ad,
                                bit f, logic [1:0] c, logic [31:0] fa);
        vec_t v;
        v.pc = p; v.inv = i; v.rdy = r;
        v.e_stall = st; v.e_instr = ins;
        v.e_req = rq; v.e_addr = ad;
        v.e_fault = f; v.e_cause = c; v.e_faddr = fa;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Advance one clock; memory model answers accepted requests after 'delay' cycles.
    task automatic next_cycle();
        logic        a;
        logic [31:0] ad;
        a  = bus.imem_req_valid & bus.imem_req_ready;
        ad = bus.imem_req_addr;
        @(posedge clk);
        #1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_err   = 1'b0;
        if (a === 1'b1 && mem_en) begin
            cnt       = delay;
            pend_addr = ad;
        end
        if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = mem[pend_addr[4:2]];
                bus.imem_rsp_err   = err_mode;
            end
        end
    endtask

    task automatic apply(vec_t v, string nm);
        pc  = v.pc;
        inv = v.inv;
        bus.imem_req_ready = v.rdy;
        #1;
        chk({nm, ".stall"}, 32'(stall), 32'(v.e_stall));
        chk({nm, ".instr"}, instr, v.e_instr);
        chk({nm, ".req_valid"}, 32'(bus.imem_req_valid), 32'(v.e_req));
        if (v.e_req)
            chk({nm, ".req_addr"}, bus.imem_req_addr, v.e_addr);
        chk({nm, ".fault"}, 32'(fault), 32'(v.e_fault));
        if (v.e_fault) begin
            chk({nm, ".cause"}, 32'(cause), 32'(v.e_cause));
            chk({nm, ".faddr"}, faddr, v.e_faddr);
        end
        next_cycle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        inv   = 1'b0;
        pc    = '0;
        bus.imem_req_ready = 1'b1;
        next_cycle();
        next_cycle();
        cnt = 0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_err   = 1'b0;
        mem_en   = 1'b1;
        err_mode = 1'b0;
        delay    = 1;
        #1;
        chk("rst.stall", 32'(stall), 32'd1);
        chk("rst.instr", instr, NOP);
        chk("rst.req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("rst.fault", 32'(fault), 32'd0);
        chk("rst.cause", 32'(cause), 32'd0);
        chk("rst.faddr", faddr, 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 32'h0;
        mem[0] = I0;
        mem[1] = I1;
        mem[4] = X1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.imem_rsp_err   = 1'b0;
        bus.imem_req_ready = 1'b1;
        cnt = 0; delay = 1; mem_en = 1'b1; err_mode = 1'b0;
        pend_addr = '0;

        // Miss latency, hit hold, ready back-pressure, re-miss.
        tbl.push_back(mk(0, 0, 1, 1, NOP, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, NOP, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, NOP, 0, 0, 0, 0, 0));
        for (int i = 0; i < 6; i++)
            tbl.push_back(mk(0, 0, 1, 0, I0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(4, 0, 0, 1, NOP, 0, 0, 0, 0, 0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(4, 0, 0, 1, NOP, 1, 4, 0, 0, 0));
        tbl.push_back(mk(4, 0, 1, 1, NOP, 1, 4, 0, 0, 0));
        tbl.push_back(mk(4, 0, 1, 1, NOP, 0, 0, 0, 0, 0));
        tbl.push_back(mk(4, 0, 1, 0, I1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, NOP, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, NOP, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, NOP, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, I0, 0, 0, 0, 0, 0));

        do_reset();
        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // Misaligned PC: fault next cycle, never a request.
        do_reset();
        apply(mk(6, 0, 1, 1, NOP, 0, 0, 0, 0, 0), "mis0");
        for (int i = 0; i < 3; i++)
            apply(mk(6, 0, 1, 1, NOP, 0, 0, 1, 2'b01, 6), "mis");

        // Bus error response.
        do_reset();
        err_mode = 1'b1;
        apply(mk(8, 0, 1, 1, NOP, 0, 0, 0, 0, 0), "err0");
        apply(mk(8, 0, 1, 1, NOP, 1, 8, 0, 0, 0), "err1");
        apply(mk(8, 0, 1, 1, NOP, 0, 0, 0, 0, 0), "err2");
        for (int i = 0; i < 2; i++)
            apply(mk(8, 0, 1, 1, NOP, 0, 0, 1, 2'b10, 8), "err");
        err_mode = 1'b0;

        // Timeout after 8 WAIT cycles with no response.
        do_reset();
        mem_en = 1'b0;
        apply(mk(32'hC, 0, 1, 1, NOP, 0, 0, 0, 0, 0), "to0");
        apply(mk(32'hC, 0, 1, 1, NOP, 1, 32'hC, 0, 0, 0), "to1");
        for (int i = 0; i < 8; i++)
            apply(mk(32'hC, 0, 1, 1, NOP, 0, 0, 0, 0, 0),
                  $sformatf("to_wait%0d", i + 1));
        for (int i = 0; i < 2; i++)
            apply(mk(32'hC, 0, 1, 1, NOP, 0, 0, 1, 2'b11, 32'hC), "to_flt");
        mem_en = 1'b1;

        // Invalidate during WAIT: first response dropped, refetch delivers new data.
        do_reset();
        delay = 3;
        apply(mk(32'h10, 0, 1, 1, NOP, 0, 0, 0, 0, 0), "inv0");
        apply(mk(32'h10, 0, 1, 1, NOP, 1, 32'h10, 0, 0, 0), "inv1");
        apply(mk(32'h10, 1, 1, 1, NOP, 0, 0, 0, 0, 0), "inv2");
        apply(mk(32'h10, 0, 1, 1, NOP, 0, 0, 0, 0, 0), "inv3");
        mem[4] = X2;
        apply(mk(32'h10, 0, 1, 1, NOP, 0, 0, 0, 0, 0), "inv4");
        apply(mk(32'h10, 0, 1, 1, NOP, 0, 0, 0, 0, 0), "inv5");
        apply(mk(32'h10, 0, 1, 1, NOP, 1, 32'h10, 0, 0, 0), "inv6");
        for (int i = 7; i < 10; i++)
            apply(mk(32'h10, 0, 1, 1, NOP, 0, 0, 0, 0, 0),
                  $sformatf("inv%0d", i));
        apply(mk(32'h10, 1, 1, 0, X2, 0, 0, 0, 0, 0), "inv10");
        apply(mk(32'h10, 0, 1, 1, NOP, 0, 0, 0, 0, 0), "inv11");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
